// File: rtl/three_way_block_packer.sv
// three_way_block_packer: packs 32-bit stream words into zero-padded 96-bit blocks,
// flushing early on tlast, with a single registered output slot.
module three_way_block_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [95:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic [1:0]  m_axis_tnwords,
    input  logic        m_axis_tready
);
    logic [1:0]  cnt;
    logic [63:0] acc;
    logic [95:0] blk;
    logic        s_xfer;
    logic        done;

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign s_xfer = s_axis_tvalid && s_axis_tready;
    assign done = s_xfer && (cnt == 2'd2 || s_axis_tlast);
    // Words above the current index are always zero in acc, so padding comes for free.
    assign blk = {cnt == 2'd2 ? s_axis_tdata : 32'd0,
                  cnt == 2'd1 ? s_axis_tdata : acc[63:32],
                  cnt == 2'd0 ? s_axis_tdata : acc[31:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 2'd0;
            acc <= 64'd0;
            m_axis_tdata <= 96'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast <= 1'b0;
            m_axis_tnwords <= 2'd0;
        end else begin
            if (m_axis_tvalid && m_axis_tready)
                m_axis_tvalid <= 1'b0;
            if (done) begin
                m_axis_tdata <= blk;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast <= s_axis_tlast;
                m_axis_tnwords <= cnt + 2'd1;
                cnt <= 2'd0;
                acc <= 64'd0;
            end else if (s_xfer) begin
                acc <= blk[63:0];
                cnt <= cnt + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_three_way_block_packer.sv
// tb_three_way_block_packer: directed and random stimulus checked against a
// queue-based block model.
module tb_three_way_block_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_data = 32'd0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_axis_tready;
    logic [95:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic [1:0]  m_axis_tnwords;
    logic        m_ready = 1'b1;

    int tests = 0;
    int fails = 0;
    int dut_xfers = 0;

    logic [31:0] w[$];
    bit          sv = 1'b0;
    logic [95:0] sd = 96'd0;
    logic        sl = 1'b0;
    logic [1:0]  sn = 2'd0;

    three_way_block_packer dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tnwords(m_axis_tnwords),
        .m_axis_tready(m_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model at negedge, advance the model, return after posedge.
    task automatic step();
        logic er;
        @(negedge clk);
        er = !sv || m_ready;
        chk("s_ready", s_axis_tready, er);
        chk("m_valid", m_axis_tvalid, sv);
        if (sv) begin
            chk("m_data", m_axis_tdata, sd);
            chk("m_last", m_axis_tlast, sl);
            chk("m_nwords", m_axis_tnwords, sn);
        end
        if (m_axis_tvalid && m_ready && !rst) dut_xfers++;
        if (rst) begin
            sv = 1'b0; sd = 96'd0; sl = 1'b0; sn = 2'd0;
            w.delete();
        end else begin
            if (sv && m_ready) sv = 1'b0;
            if (s_valid && er) begin
                w.push_back(s_data);
                if (w.size() == 3 || s_last) begin
                    sd = 96'd0;
                    foreach (w[i]) sd[32*i +: 32] = w[i];
                    sl = s_last;
                    sn = 2'(w.size());
                    sv = 1'b1;
                    w.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [31:0] d, input logic l);
        s_valid = 1'b1; s_data = d; s_last = l;
        step();
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    initial begin
        int x0;
        // Reset with valid input offered
        rst = 1'b1; s_valid = 1'b1; s_data = 32'hDEADBEEF; s_last = 1'b1;
        step(); step();
        chk("rst_data", m_axis_tdata, 96'd0);
        chk("rst_valid", m_axis_tvalid, 1'b0);
        chk("rst_last", m_axis_tlast, 1'b0);
        chk("rst_nwords", m_axis_tnwords, 2'd0);
        rst = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        chk("rst_ready", s_axis_tready, 1'b1);
        step();
        // Full block
        word(32'h11111111, 1'b0); word(32'h22222222, 1'b0); word(32'h33333333, 1'b0);
        chk("full_data", m_axis_tdata, 96'h333333332222222211111111);
        chk("full_nwords", m_axis_tnwords, 2'd3);
        chk("full_last", m_axis_tlast, 1'b0);
        step();
        // Partial blocks
        word(32'hAAAAAAAA, 1'b0); word(32'hBBBBBBBB, 1'b1);
        chk("part_data", m_axis_tdata, 96'h00000000BBBBBBBBAAAAAAAA);
        chk("part_nwords", m_axis_tnwords, 2'd2);
        chk("part_last", m_axis_tlast, 1'b1);
        word(32'h5, 1'b1);
        chk("single_data", m_axis_tdata, 96'h5);
        chk("single_nwords", m_axis_tnwords, 2'd1);
        step();
        // Backpressure with input offered throughout
        m_ready = 1'b0;
        word(32'hCAFEF00D, 1'b1);
        x0 = dut_xfers;
        s_valid = 1'b1; s_data = 32'h12345678;
        for (int i = 0; i < 10; i++) step();
        chk("bp_ready", s_axis_tready, 1'b0);
        chk("bp_data", m_axis_tdata, 96'hCAFEF00D);
        s_valid = 1'b0; m_ready = 1'b1;
        step(); step(); step();
        chk("bp_once", 96'(dut_xfers - x0), 96'd1);
        // Streaming 9 words
        for (int i = 0; i < 9; i++) word(32'h100 + 32'(i), i == 8);
        chk("stream_last", m_axis_tlast, 1'b1);
        chk("stream_data", m_axis_tdata, {32'h108, 32'h107, 32'h106});
        step();
        // Mid-block reset
        word(32'hEEEEEEEE, 1'b0); word(32'hFFFFFFFF, 1'b0);
        rst = 1'b1; step(); rst = 1'b0;
        word(32'h1, 1'b0); word(32'h2, 1'b0); word(32'h3, 1'b0);
        chk("mid_rst_data", m_axis_tdata, 96'h000000030000000200000001);
        chk("mid_rst_nwords", m_axis_tnwords, 2'd3);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data = $urandom;
            s_last = ($urandom_range(0, 4) == 0);
            m_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        step(); step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/three_way_block_packer.md
THREE_WAY_BLOCK_PACKER -- requirements
Module: three_way_block_packer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 s_axis_tdata  input  32  plaintext word from the host stream.
REQ-005 s_axis_tvalid  input  1  word valid.
REQ-006 s_axis_tlast  input  1  marks the last word of a message.
REQ-007 s_axis_tready  output  1  block accepts the word this cycle.
REQ-008 m_axis_tdata  output  96  assembled block, fed to the 3-Way pipeline input.
REQ-009 m_axis_tvalid  output  1  block valid.
REQ-010 m_axis_tlast  output  1  block contains the last word of a message.
REQ-011 m_axis_tnwords  output  2  number of real words in the block (1..3); the remaining words are zero padding.
REQ-012 m_axis_tready  input  1  downstream accepts the block.

Function
REQ-013 An input word SHALL transfer only when s_axis_tvalid and s_axis_tready are both 1 at a rising clk edge.
REQ-014 An output block SHALL transfer only when m_axis_tvalid and m_axis_tready are both 1 at a rising clk edge.
REQ-015 The word counter SHALL hold 0..2 and SHALL advance on each input transfer.
REQ-016 Word placement: word index 0 -> bits [31:0], index 1 -> [63:32], index 2 -> [95:64].
REQ-017 A block SHALL complete when an input transfer occurs at index 2 or with s_axis_tlast=1.
REQ-018 On completion, the output register SHALL load at the same edge: all accumulated words plus the completing word, with unfilled words set to 0.
REQ-019 On completion, m_axis_tnwords SHALL equal index+1, m_axis_tlast SHALL equal the completing word's s_axis_tlast, and m_axis_tvalid SHALL be set.
REQ-020 On completion, the counter and accumulator SHALL clear to 0.
REQ-021 s_axis_tready SHALL be defined as (!m_axis_tvalid || m_axis_tready), purely combinational from registered state and m_axis_tready.
REQ-022 When an output transfer occurs with no simultaneous completion, m_axis_tvalid SHALL clear at that edge.
REQ-023 When an output transfer and a completion coincide, the new block SHALL load and m_axis_tvalid SHALL remain 1, giving no bubble.
REQ-024 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tlast and m_axis_tnwords SHALL hold stable.
REQ-025 Latency SHALL be 1 cycle from the completing input transfer to m_axis_tvalid=1.
REQ-026 Sustained throughput SHALL be one word per cycle with m_axis_tready held at 1.
REQ-027 A tlast at index 2 SHALL produce a full block with tnwords=3 and tlast=1; no extra padding block is emitted.
REQ-028 A message whose length is a multiple of 3 words SHALL produce no partial or empty trailing block.
REQ-029 Input with s_axis_tvalid=0 SHALL leave the counter and accumulator unchanged, with no timeout flush.

Reset
REQ-030 While rst=1, the block SHALL set m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tnwords=0, the counter to 0 and the accumulator to 0.
REQ-031 A reset asserted mid-block or during output stall SHALL discard partial and pending data; s_axis_tready is 1 in the first cycle after rst deasserts.
REQ-032 Input transfers SHALL be ignored in any cycle where rst=1.

Verification
REQ-033 Reset: assert rst with tvalid high -> all outputs 0; s_axis_tready=1 after release.
REQ-034 Full block: words 0x11111111, 0x22222222, 0x33333333, m_axis_tready=1 -> one cycle after the third word: tdata=0x333333332222222211111111, tnwords=3, tlast=0.
REQ-035 Partial block: words 0xAAAAAAAA, 0xBBBBBBBB(tlast) -> tdata=0x00000000BBBBBBBBAAAAAAAA, tnwords=2, tlast=1; a single-word tlast 0x5 -> tdata=0x5, tnwords=1.
REQ-036 Backpressure: hold m_axis_tready=0 with a block pending -> s_axis_tready=0 and outputs stable for 10 cycles; release -> block transferred exactly once.
REQ-037 Streaming: 9 words back-to-back, m_axis_tready=1 -> 3 blocks on cycles 4, 7, 10 with no input stall, last block tlast per the input.
REQ-038 Mid-block reset: 2 words, then rst for 1 cycle, then words 0x1, 0x2, 0x3 -> single block 0x000000030000000200000001, no stale data.
